// File: rtl/store_narrow_buffer_pkg.sv
// Shared encodings and types for the narrow-store buffer: access sizes,
// byte-enable constants, per-entry lane record and the misalignment rule.
package store_narrow_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Lane-replicated data and byte enables as presented to memory.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  // Reserved size is narrowed like a word but is never treated as misaligned.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store narrowing: replicates the register value across byte
// lanes and derives byte enables from the access size and low address bits.
module store_align
  import store_narrow_buffer_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output lane_t       lane
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    lane.wdata = data;
    lane.be    = BE_WORD;
    case (size)
      SZ_BYTE: begin
        lane.wdata = {4{data[7:0]}};
        lane.be    = BE_BYTE0 << addr_lo;
      end
      SZ_HALF: begin
        lane.wdata = {2{data[15:0]}};
        lane.be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// In-order store buffer that narrows byte/half/word stores at enqueue time.
// Optional MISALIGN_TRAP_EN drops misaligned requests and pulses misalign.
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [31:0]            req_data,
  input  logic [1:0]             req_size,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic [$clog2(DEPTH):0] count
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                   misalign
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  lane_t          in_lane;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           accept;
  logic           push;
  logic           pop;

  lane_t          lane_mem [DEPTH];
  logic [AW-3:0]  addr_mem [DEPTH];

  store_align u_align (
    .size    (size_e'(req_size)),
    .addr_lo (req_addr[1:0]),
    .data    (req_data),
    .lane    (in_lane)
  );

  // Ready depends only on occupancy, never on mem_ready.
  assign req_ready = (count != FULL);
  assign mem_valid = (count != '0);
  assign accept    = req_valid & req_ready;
  assign pop       = mem_valid & mem_ready;

`ifdef MISALIGN_TRAP_EN
  logic trap;

  assign trap = is_misaligned(size_e'(req_size), req_addr[1:0]);
  assign push = accept & ~trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= accept & trap;
  end
`else
  assign push = accept;
`endif

  // DEPTH is a power of two, so pointer increments wrap to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: entry storage has no reset; count gates visibility, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) begin
      lane_mem[wr_ptr] <= in_lane;
      addr_mem[wr_ptr] <= req_addr[AW-1:2];
    end
  end

  assign mem_addr  = {addr_mem[rd_ptr], 2'b00};
  assign mem_wdata = lane_mem[rd_ptr].wdata;
  assign mem_be    = lane_mem[rd_ptr].be;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed bench for store_narrow_buffer: narrowing table, fill/stall,
// streaming drain with wrap, reset mid-drain, and the MISALIGN_TRAP_EN option.
module tb_store_narrow_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_narrow_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .count     (count)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q[$];
    int next_idx;
    bit push_m;
    bit pop_m;

    vecs[0] = '{32'h0000_1003, 32'hAABB_CCDD, 2'b00, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000};
    vecs[1] = '{32'h0000_2002, 32'h1234_5678, 2'b01, 32'h0000_2000, 32'h5678_5678, 4'b1100};
    vecs[2] = '{32'h0000_2000, 32'h1234_5678, 2'b01, 32'h0000_2000, 32'h5678_5678, 4'b0011};
    vecs[3] = '{32'h0000_0040, 32'h0000_00EF, 2'b00, 32'h0000_0040, 32'hEFEF_EFEF, 4'b0001};
    vecs[4] = '{32'h0000_0041, 32'h1122_3344, 2'b00, 32'h0000_0040, 32'h4444_4444, 4'b0010};
    vecs[5] = '{32'h0000_0100, 32'hCAFE_F00D, 2'b10, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111};
    vecs[6] = '{32'h0000_0107, 32'h0102_0304, 2'b11, 32'h0000_0104, 32'h0102_0304, 4'b1111};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = 2'b00;
    mem_ready = 1'b0;

    @(negedge clk);
    check("reset mem_valid", 32'(mem_valid), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset count", 32'(count), 32'd0);
    @(negedge clk);

    // Reset released mid-cycle; the first request is taken on the next rising edge.
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      req_data  = vecs[i].data;
      req_size  = vecs[i].size;
      mem_ready = 1'b0;
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("vec%0d mem_valid", i), 32'(mem_valid), 32'd1);
      check($sformatf("vec%0d count", i), 32'(count), 32'd1);
      check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
      mem_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d drained", i), 32'(count), 32'd0);
      check($sformatf("vec%0d mem_valid low", i), 32'(mem_valid), 32'd0);
    end
    mem_ready = 1'b0;

`ifdef MISALIGN_TRAP_EN
    req_valid = 1'b1;
    req_addr  = 32'h0000_3001;
    req_data  = 32'h55AA_55AA;
    req_size  = 2'b10;
    check("trap word ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("trap word misalign", 32'(misalign), 32'd1);
    check("trap word count", 32'(count), 32'd0);
    check("trap word no write", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("trap word pulse end", 32'(misalign), 32'd0);
    check("trap word still empty", 32'(count), 32'd0);
    req_valid = 1'b1;
    req_addr  = 32'h0000_2001;
    req_size  = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    check("trap half misalign", 32'(misalign), 32'd1);
    check("trap half count", 32'(count), 32'd0);
    @(negedge clk);
    check("trap half pulse end", 32'(misalign), 32'd0);
`else
    req_valid = 1'b1;
    req_addr  = 32'h0000_3001;
    req_data  = 32'h55AA_55AA;
    req_size  = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    check("unaligned word count", 32'(count), 32'd1);
    check("unaligned word mem_addr", mem_addr, 32'h0000_3000);
    check("unaligned word mem_wdata", mem_wdata, 32'h55AA_55AA);
    check("unaligned word mem_be", 32'(mem_be), 32'hF);
    mem_ready = 1'b1;
    @(negedge clk);
    check("unaligned word drained", 32'(count), 32'd0);
    mem_ready = 1'b0;
`endif

    // Fill with memory stalled.
    q.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0000_0500 + 32'(i * 4);
      req_data  = 32'hA000_0000 + 32'(i);
      req_size  = 2'b10;
      @(negedge clk);
      q.push_back(i);
      check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
    end
    check("full req_ready", 32'(req_ready), 32'd0);

    // Fifth request held while full; head must stay put.
    next_idx = 4;
    req_addr = 32'h0000_0500 + 32'(next_idx * 4);
    req_data = 32'hA000_0000 + 32'(next_idx);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d count", c), 32'(count), 32'd4);
      check($sformatf("stall%0d ready", c), 32'(req_ready), 32'd0);
      check($sformatf("stall%0d mem_addr", c), mem_addr, 32'h0000_0500);
      check($sformatf("stall%0d mem_wdata", c), mem_wdata, 32'hA000_0000);
      check($sformatf("stall%0d mem_be", c), 32'(mem_be), 32'hF);
    end

    // Stream with both sides active; a full buffer only pops on the first cycle.
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0000_0500 + 32'(next_idx * 4);
      req_data  = 32'hA000_0000 + 32'(next_idx);
      mem_ready = 1'b1;
      check($sformatf("stream%0d count", c), 32'(count), 32'(q.size()));
      check($sformatf("stream%0d ready", c), 32'(req_ready), 32'(q.size() != 4));
      check($sformatf("stream%0d mem_wdata", c), mem_wdata, 32'hA000_0000 + 32'(q[0]));
      check($sformatf("stream%0d mem_addr", c), mem_addr, 32'h0000_0500 + 32'(q[0] * 4));
      push_m = (q.size() != 4);
      pop_m  = (q.size() != 0);
      @(posedge clk);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(next_idx);
        next_idx++;
      end
      @(negedge clk);
    end
    check("stream final count", 32'(count), 32'(q.size()));

    // Reset pulse mid-drain with entries still buffered.
    req_valid = 1'b0;
    mem_ready = 1'b1;
    check("pre-reset count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mem_valid", 32'(mem_valid), 32'd0);
    check("async reset count", 32'(count), 32'd0);
    check("async reset req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("empty pop ignored count", 32'(count), 32'd0);
    check("empty pop ignored valid", 32'(mem_valid), 32'd0);

    // Operation resumes normally after reset.
    mem_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_1003;
    req_data  = 32'hAABB_CCDD;
    req_size  = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    check("post-reset count", 32'(count), 32'd1);
    check("post-reset mem_wdata", mem_wdata, 32'hDDDD_DDDD);
    check("post-reset mem_be", 32'(mem_be), 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_buffer.md
STORE_NARROW_BUFFER -- requirements
Module: store_narrow_buffer

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4: number of store entries; power of two, at least 2.
REQ-002 The block SHALL have parameter AW, default 32: byte-address width.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a store request is presented.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_addr, input, AW bits: byte address.
REQ-008 The block SHALL have port req_data, input, 32 bits: register value; only the low bytes are used for narrow stores.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-010 The block SHALL have port mem_valid, output, 1 bit: the head entry is presented to memory.
REQ-011 The block SHALL have port mem_ready, input, 1 bit: memory accepts the head entry.
REQ-012 The block SHALL have port mem_addr, output, AW bits: word-aligned address with bits [1:0] = 00.
REQ-013 The block SHALL have port mem_wdata, output, 32 bits: lane-replicated write data.
REQ-014 The block SHALL have port mem_be, output, 4 bits: byte enables; bit i enables byte lane i.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of occupied entries.
REQ-016 The block SHALL have port misalign, output, 1 bit: misalignment pulse; present only with MISALIGN_TRAP_EN.

Function
REQ-017 A request SHALL be accepted in a cycle where req_valid and req_ready are both 1.
REQ-018 req_ready SHALL equal (count != DEPTH); it SHALL NOT depend on mem_ready (no full-and-pop pass-through).
REQ-019 Narrowing SHALL be computed at enqueue and stored per entry:
- byte: wdata = {4{req_data[7:0]}}, be = 0001 << req_addr[1:0].
- halfword: wdata = {2{req_data[15:0]}}, be = 1100 if req_addr[1] = 1, else 0011.
- word and reserved (11): wdata = req_data, be = 1111.
REQ-020 mem_addr SHALL equal {req_addr[AW-1:2], 2'b00} of the stored entry.
REQ-021 Entries SHALL drain in acceptance order; a pop SHALL occur when mem_valid and mem_ready are both 1.
REQ-022 Latency: a request accepted in cycle N into an empty buffer SHALL appear with mem_valid = 1 in cycle N+1; there SHALL be no combinational path from req_* to mem_*.
REQ-023 mem_valid SHALL equal (count != 0).
REQ-024 While mem_valid = 1 and mem_ready = 0, mem_addr, mem_wdata and mem_be SHALL hold stable.
REQ-025 A push and a pop in the same cycle SHALL leave count unchanged; both read and write pointers SHALL advance.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 mem_ready asserted while the buffer is empty SHALL have no effect.
REQ-028 count SHALL never exceed DEPTH and never underflow.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear both pointers and count, and force mem_valid = 0, req_ready = 1 and misalign = 0.
REQ-030 Reset during operation SHALL discard all buffered entries; memory outputs SHALL NOT be guaranteed to hold.
REQ-031 Entry data storage SHALL NOT require reset.
REQ-032 Release of rst_n SHALL be usable asynchronously; the first request SHALL be accepted on the first rising edge after release.

Configuration
REQ-033 With macro MISALIGN_TRAP_EN defined:
- a halfword request with req_addr[0] = 1, or a word request with req_addr[1:0] != 00, SHALL be consumed (req_ready honoured) but SHALL NOT be enqueued.
- misalign SHALL be registered high for exactly one cycle after such a request.
REQ-034 Without MISALIGN_TRAP_EN:
- the misalign port SHALL be absent.
- address bits below the access size SHALL be ignored per REQ-019, and every accepted request SHALL be enqueued.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the byte-enable constants BE_WORD, BE_HALF_LO and BE_HALF_HI.
REQ-036 The narrowing of REQ-019 SHALL be one combinational sub-module, store_align, instantiated at the enqueue port.
REQ-037 Storage, pointers and count SHALL reside in store_narrow_buffer.

Verification
REQ-038 Bench SHALL drive a byte store, addr 0x1003, data 0xAABBCCDD, into an empty buffer -> next cycle mem_addr = 0x1000, mem_wdata = 0xDDDDDDDD, mem_be = 1000.
REQ-039 Bench SHALL drive a half store, addr 0x2002, data 0x12345678 -> mem_wdata = 0x56785678, mem_be = 1100.
REQ-040 Bench SHALL hold mem_ready = 0 and push 4 words -> req_ready = 0 and count = 4, the fifth request is stalled, and outputs hold stable.
REQ-041 Bench SHALL fill the buffer, then hold req_valid = 1 and mem_ready = 1 for 10 cycles -> order preserved, pointers wrap, count steady after the first pop.
REQ-042 Bench SHALL pulse rst_n low mid-drain with 3 entries buffered -> mem_valid = 0 immediately and count = 0.
REQ-043 Bench SHALL build with MISALIGN_TRAP_EN and send a word store at addr 0x3001 -> misalign = 1 for one cycle, count unchanged, and no memory write.
